// File: rtl/sdio_txrx_seq.sv
`default_nettype none
// ============================================================================
// Module  : sdio_txrx_seq
// Brief   : SDIO uDMA transaction sequencer - drives the command and data
//           engines through a request with optional auto-CMD12 / auto-CMD23,
//           watchdog timeout and sticky error status.
// Revision: 1.0 - initial release
// ============================================================================
module sdio_txrx_seq #(
    parameter int BLKNUM_W  = 16,
    parameter int TIMEOUT_W = 24,
    parameter int STOP_OP   = 12,
    parameter int SETCNT_OP = 23
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_stat_i,
    input  logic                 req_i,
    input  logic [5:0]           req_op_i,
    input  logic [31:0]          req_arg_i,
    input  logic [2:0]           req_rsp_type_i,
    input  logic                 req_data_en_i,
    input  logic                 req_rwn_i,
    input  logic [BLKNUM_W-1:0]  req_blk_num_i,
    input  logic [1:0]           req_auto_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    output logic                 busy_o,
    output logic                 eot_o,
    output logic                 err_o,
    output logic                 abort_o,
    output logic [7:0]           status_o,
    output logic                 cmd_start_o,
    output logic [5:0]           cmd_op_o,
    output logic [31:0]          cmd_arg_o,
    output logic [2:0]           cmd_rsp_type_o,
    input  logic                 cmd_eot_i,
    input  logic                 cmd_err_i,
    input  logic                 cmd_data_go_i,
    output logic                 data_start_o,
    output logic                 data_rwn_o,
    output logic [BLKNUM_W-1:0]  data_blk_num_o,
    input  logic                 data_last_i,
    input  logic                 data_eot_i,
    input  logic                 data_err_i
);

    localparam logic [5:0] c_STOP_OP     = 6'(STOP_OP);
    localparam logic [5:0] c_SETCNT_OP   = 6'(SETCNT_OP);
    localparam logic [2:0] c_RSP_R1      = 3'd1;
    localparam logic [1:0] c_AUTO_STOP   = 2'd1;
    localparam logic [1:0] c_AUTO_SETCNT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETCNT = 3'd1,
        ST_MAIN   = 3'd2,
        ST_STOP   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                r_state;
    logic [5:0]            r_op;
    logic [31:0]           r_arg;
    logic [2:0]            r_rsp;
    logic                  r_data_en;
    logic                  r_rwn;
    logic [BLKNUM_W-1:0]   r_blk_num;
    logic [1:0]            r_auto;
    logic                  r_c_done;
    logic                  r_d_done;
    logic                  r_l_seen;
    logic                  r_s_done;
    logic                  r_go_seen;
    logic                  r_seq_err;
    logic [TIMEOUT_W-1:0]  r_wd;
    logic                  r_cmd_start;
    logic [5:0]            r_cmd_op;
    logic [31:0]           r_cmd_arg;
    logic [2:0]            r_cmd_rsp;
    logic                  r_data_start;
    logic                  r_eot;
    logic                  r_err;
    logic                  r_abort;
    logic [7:0]            r_status;

    logic                  w_active;
    logic                  w_reload;
    logic                  w_timeout;
    logic                  w_cmd_err;
    logic                  w_data_err;
    logic                  w_err_any;
    logic [1:0]            w_req_auto;
    logic [BLKNUM_W:0]     w_setcnt_cnt;
    logic [31:0]           w_setcnt_arg;
    logic                  w_auto_stop;
    logic                  w_c_done;
    logic                  w_d_done;
    logic                  w_l_seen;
    logic                  w_s_done;
    logic                  w_to_stop;
    logic                  w_main_done;
    logic                  w_stop_done;
    logic [7:0]            w_stat_set;
    logic [7:0]            w_status_next;

    assign w_active   = (r_state == ST_SETCNT) || (r_state == ST_MAIN) || (r_state == ST_STOP);
    assign w_reload   = cmd_eot_i | data_last_i | data_eot_i;
    // Any handshake in the expiry cycle reloads the watchdog instead of aborting.
    assign w_timeout  = w_active && (timeout_i != '0) && (r_wd == '0) && !w_reload;
    assign w_cmd_err  = cmd_eot_i & cmd_err_i;
    assign w_data_err = data_eot_i & data_err_i;
    assign w_err_any  = r_seq_err | w_cmd_err | w_data_err;

    assign w_req_auto   = (req_auto_i == 2'd3) ? 2'd0 : req_auto_i;
    // One extra bit so blk_num = all-ones does not wrap to zero blocks.
    assign w_setcnt_cnt = {1'b0, req_blk_num_i} + 1'b1;
    assign w_setcnt_arg = 32'(w_setcnt_cnt);

    assign w_auto_stop = r_data_en && (r_auto == c_AUTO_STOP) && (r_blk_num != '0);
    assign w_c_done    = r_c_done | cmd_eot_i;
    assign w_d_done    = r_d_done | data_eot_i;
    assign w_l_seen    = r_l_seen | data_last_i;
    assign w_s_done    = r_s_done | cmd_eot_i;

    assign w_to_stop   = (r_state == ST_MAIN) && w_auto_stop && w_l_seen && w_c_done;
    assign w_main_done = (r_state == ST_MAIN) && !w_auto_stop && w_c_done &&
                         (w_d_done || !r_data_en);
    assign w_stop_done = (r_state == ST_STOP) && w_s_done && w_d_done;

    assign w_stat_set = {2'b00,
                         req_i && (r_state != ST_IDLE),
                         w_to_stop,
                         (r_state == ST_SETCNT) && w_cmd_err,
                         w_timeout,
                         w_active && w_data_err,
                         w_active && w_cmd_err};
    assign w_status_next = (clr_stat_i ? 8'h00 : r_status) | w_stat_set;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_op         <= '0;
            r_arg        <= '0;
            r_rsp        <= '0;
            r_data_en    <= 1'b0;
            r_rwn        <= 1'b0;
            r_blk_num    <= '0;
            r_auto       <= '0;
            r_c_done     <= 1'b0;
            r_d_done     <= 1'b0;
            r_l_seen     <= 1'b0;
            r_s_done     <= 1'b0;
            r_go_seen    <= 1'b0;
            r_seq_err    <= 1'b0;
            r_wd         <= '0;
            r_cmd_start  <= 1'b0;
            r_cmd_op     <= '0;
            r_cmd_arg    <= '0;
            r_cmd_rsp    <= '0;
            r_data_start <= 1'b0;
            r_eot        <= 1'b0;
            r_err        <= 1'b0;
            r_abort      <= 1'b0;
            r_status     <= '0;
        end else begin
            r_cmd_start  <= 1'b0;
            r_data_start <= 1'b0;
            r_eot        <= 1'b0;
            r_err        <= 1'b0;
            r_abort      <= 1'b0;
            r_status     <= w_status_next;

            if (w_active) begin
                if (w_reload) begin
                    r_wd <= timeout_i;
                end else if (r_wd != '0) begin
                    r_wd <= r_wd - 1'b1;
                end
                if (w_cmd_err || w_data_err) begin
                    r_seq_err <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (req_i) begin
                        r_op        <= req_op_i;
                        r_arg       <= req_arg_i;
                        r_rsp       <= req_rsp_type_i;
                        r_data_en   <= req_data_en_i;
                        r_rwn       <= req_rwn_i;
                        r_blk_num   <= req_blk_num_i;
                        r_auto      <= w_req_auto;
                        r_c_done    <= 1'b0;
                        r_d_done    <= 1'b0;
                        r_l_seen    <= 1'b0;
                        r_s_done    <= 1'b0;
                        r_go_seen   <= 1'b0;
                        r_seq_err   <= 1'b0;
                        r_wd        <= timeout_i;
                        r_cmd_start <= 1'b1;
                        if ((w_req_auto == c_AUTO_SETCNT) && req_data_en_i) begin
                            r_state   <= ST_SETCNT;
                            r_cmd_op  <= c_SETCNT_OP;
                            r_cmd_arg <= w_setcnt_arg;
                            r_cmd_rsp <= c_RSP_R1;
                        end else begin
                            r_state   <= ST_MAIN;
                            r_cmd_op  <= req_op_i;
                            r_cmd_arg <= req_arg_i;
                            r_cmd_rsp <= req_rsp_type_i;
                        end
                    end
                end

                ST_SETCNT: begin
                    if (w_cmd_err) begin
                        r_state <= ST_DONE;
                        r_wd    <= timeout_i;
                        r_eot   <= 1'b1;
                        r_err   <= 1'b1;
                    end else if (cmd_eot_i) begin
                        r_state     <= ST_MAIN;
                        r_wd        <= timeout_i;
                        r_cmd_start <= 1'b1;
                        r_cmd_op    <= r_op;
                        r_cmd_arg   <= r_arg;
                        r_cmd_rsp   <= r_rsp;
                    end else if (w_timeout) begin
                        r_state   <= ST_DONE;
                        r_wd      <= timeout_i;
                        r_abort   <= 1'b1;
                        r_eot     <= 1'b1;
                        r_err     <= 1'b1;
                        r_seq_err <= 1'b1;
                    end
                end

                ST_MAIN: begin
                    if (cmd_eot_i)   r_c_done <= 1'b1;
                    if (data_eot_i)  r_d_done <= 1'b1;
                    if (data_last_i) r_l_seen <= 1'b1;
                    if (r_data_en && cmd_data_go_i && !r_go_seen) begin
                        r_go_seen    <= 1'b1;
                        r_data_start <= 1'b1;
                    end
                    if (w_to_stop) begin
                        r_state     <= ST_STOP;
                        r_wd        <= timeout_i;
                        r_cmd_start <= 1'b1;
                        r_cmd_op    <= c_STOP_OP;
                        r_cmd_arg   <= '0;
                        r_cmd_rsp   <= c_RSP_R1;
                    end else if (w_main_done) begin
                        r_state <= ST_DONE;
                        r_wd    <= timeout_i;
                        r_eot   <= 1'b1;
                        r_err   <= w_err_any;
                    end else if (w_timeout) begin
                        r_state   <= ST_DONE;
                        r_wd      <= timeout_i;
                        r_abort   <= 1'b1;
                        r_eot     <= 1'b1;
                        r_err     <= 1'b1;
                        r_seq_err <= 1'b1;
                    end
                end

                ST_STOP: begin
                    if (cmd_eot_i)  r_s_done <= 1'b1;
                    if (data_eot_i) r_d_done <= 1'b1;
                    if (w_stop_done) begin
                        r_state <= ST_DONE;
                        r_wd    <= timeout_i;
                        r_eot   <= 1'b1;
                        r_err   <= w_err_any;
                    end else if (w_timeout) begin
                        r_state   <= ST_DONE;
                        r_wd      <= timeout_i;
                        r_abort   <= 1'b1;
                        r_eot     <= 1'b1;
                        r_err     <= 1'b1;
                        r_seq_err <= 1'b1;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o         = (r_state != ST_IDLE);
    assign eot_o          = r_eot;
    assign err_o          = r_err;
    assign abort_o        = r_abort;
    assign status_o       = r_status;
    assign cmd_start_o    = r_cmd_start;
    assign cmd_op_o       = r_cmd_op;
    assign cmd_arg_o      = r_cmd_arg;
    assign cmd_rsp_type_o = r_cmd_rsp;
    assign data_start_o   = r_data_start;
    assign data_rwn_o     = r_rwn;
    assign data_blk_num_o = r_blk_num;

endmodule
`default_nettype wire

// File: tb/tb_sdio_txrx_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_sdio_txrx_seq
// Brief   : Scoreboard bench for sdio_txrx_seq - expected commands and end
//           of transaction results are queued with the stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sdio_txrx_seq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clr_stat_i;
    logic        req_i;
    logic [5:0]  req_op_i;
    logic [31:0] req_arg_i;
    logic [2:0]  req_rsp_type_i;
    logic        req_data_en_i;
    logic        req_rwn_i;
    logic [15:0] req_blk_num_i;
    logic [1:0]  req_auto_i;
    logic [23:0] timeout_i;
    logic        busy_o, eot_o, err_o, abort_o;
    logic [7:0]  status_o;
    logic        cmd_start_o;
    logic [5:0]  cmd_op_o;
    logic [31:0] cmd_arg_o;
    logic [2:0]  cmd_rsp_type_o;
    logic        cmd_eot_i, cmd_err_i, cmd_data_go_i;
    logic        data_start_o, data_rwn_o;
    logic [15:0] data_blk_num_o;
    logic        data_last_i, data_eot_i, data_err_i;

    sdio_txrx_seq #(
        .BLKNUM_W  (16),
        .TIMEOUT_W (24),
        .STOP_OP   (12),
        .SETCNT_OP (23)
    ) u_dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clr_stat_i     (clr_stat_i),
        .req_i          (req_i),
        .req_op_i       (req_op_i),
        .req_arg_i      (req_arg_i),
        .req_rsp_type_i (req_rsp_type_i),
        .req_data_en_i  (req_data_en_i),
        .req_rwn_i      (req_rwn_i),
        .req_blk_num_i  (req_blk_num_i),
        .req_auto_i     (req_auto_i),
        .timeout_i      (timeout_i),
        .busy_o         (busy_o),
        .eot_o          (eot_o),
        .err_o          (err_o),
        .abort_o        (abort_o),
        .status_o       (status_o),
        .cmd_start_o    (cmd_start_o),
        .cmd_op_o       (cmd_op_o),
        .cmd_arg_o      (cmd_arg_o),
        .cmd_rsp_type_o (cmd_rsp_type_o),
        .cmd_eot_i      (cmd_eot_i),
        .cmd_err_i      (cmd_err_i),
        .cmd_data_go_i  (cmd_data_go_i),
        .data_start_o   (data_start_o),
        .data_rwn_o     (data_rwn_o),
        .data_blk_num_o (data_blk_num_o),
        .data_last_i    (data_last_i),
        .data_eot_i     (data_eot_i),
        .data_err_i     (data_err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] arg;
        logic [2:0]  rsp;
    } cmd_t;

    cmd_t exp_cmd[$];
    bit   exp_eot[$];

    int n_checks     = 0;
    int n_errors     = 0;
    int n_cmd_start  = 0;
    int n_data_start = 0;
    int n_abort      = 0;
    int n_eot        = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every DUT output event is matched against the queues.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (cmd_start_o) begin
                cmd_t e;
                n_cmd_start++;
                if (exp_cmd.size() == 0) begin
                    check_val("cmd_start_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_cmd.pop_front();
                    check_val("cmd_op",  32'(cmd_op_o),       32'(e.op));
                    check_val("cmd_arg", cmd_arg_o,           e.arg);
                    check_val("cmd_rsp", 32'(cmd_rsp_type_o), 32'(e.rsp));
                end
            end
            if (eot_o) begin
                bit ee;
                n_eot++;
                if (exp_eot.size() == 0) begin
                    check_val("eot_unexpected", 32'd1, 32'd0);
                end else begin
                    ee = exp_eot.pop_front();
                    check_val("eot_err", 32'(err_o), 32'(ee));
                end
            end
            if (data_start_o) n_data_start++;
            if (abort_o)      n_abort++;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic sig_sel(input int which);
        case (which)
            0:       return cmd_start_o;
            1:       return data_start_o;
            2:       return eot_o;
            default: return abort_o;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int which, input int max_cyc);
        int n = 0;
        while (!sig_sel(which) && n < max_cyc) begin
            tick();
            n++;
        end
        check_val(tag, 32'(sig_sel(which)), 32'd1);
    endtask

    task automatic send_req(input logic [5:0] op, input logic [31:0] arg, input logic [2:0] rsp,
                            input logic den, input logic rwn, input logic [15:0] blk,
                            input logic [1:0] amode);
        req_op_i       = op;
        req_arg_i      = arg;
        req_rsp_type_i = rsp;
        req_data_en_i  = den;
        req_rwn_i      = rwn;
        req_blk_num_i  = blk;
        req_auto_i     = amode;
        req_i          = 1'b1;
        tick();
        req_i          = 1'b0;
    endtask

    // which: 0 cmd_eot, 1 data_eot, 2 data_last, 3 cmd_data_go
    task automatic pulse(input int which, input logic err);
        case (which)
            0: begin cmd_eot_i = 1'b1; cmd_err_i = err; end
            1: begin data_eot_i = 1'b1; data_err_i = err; end
            2: data_last_i = 1'b1;
            default: cmd_data_go_i = 1'b1;
        endcase
        tick();
        cmd_eot_i = 1'b0; cmd_err_i = 1'b0; data_eot_i = 1'b0;
        data_err_i = 1'b0; data_last_i = 1'b0; cmd_data_go_i = 1'b0;
    endtask

    task automatic clear_status();
        clr_stat_i = 1'b1;
        tick();
        clr_stat_i = 1'b0;
    endtask

    initial begin
        int base;
        int n;
        rst_i = 1'b1; clr_stat_i = 1'b0; req_i = 1'b0;
        req_op_i = '0; req_arg_i = '0; req_rsp_type_i = '0; req_data_en_i = 1'b0;
        req_rwn_i = 1'b0; req_blk_num_i = '0; req_auto_i = '0; timeout_i = 24'd1000;
        cmd_eot_i = 1'b0; cmd_err_i = 1'b0; cmd_data_go_i = 1'b0;
        data_last_i = 1'b0; data_eot_i = 1'b0; data_err_i = 1'b0;
        repeat (3) tick();
        check_val("rst_busy",   32'(busy_o),      32'd0);
        check_val("rst_eot",    32'(eot_o),       32'd0);
        check_val("rst_status", 32'(status_o),    32'd0);
        check_val("rst_cstart", 32'(cmd_start_o), 32'd0);
        check_val("rst_cop",    32'(cmd_op_o),    32'd0);
        check_val("rst_blk",    32'(data_blk_num_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // No-data command, one-cycle start latency
        exp_cmd.push_back('{op: 6'd8, arg: 32'h1AA, rsp: 3'd1});
        exp_eot.push_back(1'b0);
        send_req(6'd8, 32'h1AA, 3'd1, 1'b0, 1'b0, 16'd0, 2'd0);
        check_val("t1_start_latency", 32'(cmd_start_o), 32'd1);
        check_val("t1_busy", 32'(busy_o), 32'd1);
        tick();
        pulse(0, 1'b0);
        wait_sig("t1_eot", 2, 20);
        tick();
        check_val("t1_idle", 32'(busy_o), 32'd0);
        check_val("t1_no_data_start", 32'(n_data_start), 32'd0);

        // Read with auto-CMD12, data_last ahead of the main response
        base = n_cmd_start;
        exp_cmd.push_back('{op: 6'd18, arg: 32'h1000, rsp: 3'd1});
        exp_cmd.push_back('{op: 6'd12, arg: 32'h0,    rsp: 3'd1});
        exp_eot.push_back(1'b0);
        send_req(6'd18, 32'h1000, 3'd1, 1'b1, 1'b1, 16'd3, 2'd1);
        tick();
        pulse(3, 1'b0);
        check_val("t2_data_start", 32'(data_start_o), 32'd1);
        check_val("t2_rwn", 32'(data_rwn_o), 32'd1);
        check_val("t2_blk", 32'(data_blk_num_o), 32'd3);
        pulse(2, 1'b0);
        repeat (3) tick();
        pulse(1, 1'b0);
        repeat (3) tick();
        check_val("t2_stop_held", 32'(n_cmd_start - base), 32'd1);
        pulse(0, 1'b0);
        check_val("t2_stop_start", 32'(cmd_start_o), 32'd1);
        tick();
        pulse(0, 1'b0);
        wait_sig("t2_eot", 2, 20);
        tick();
        check_val("t2_status", 32'(status_o), 32'h10);
        clear_status();

        // Write with auto-CMD23
        base = n_cmd_start;
        exp_cmd.push_back('{op: 6'd23, arg: 32'd8,    rsp: 3'd1});
        exp_cmd.push_back('{op: 6'd25, arg: 32'h2000, rsp: 3'd1});
        exp_eot.push_back(1'b0);
        send_req(6'd25, 32'h2000, 3'd1, 1'b1, 1'b0, 16'd7, 2'd2);
        tick();
        pulse(0, 1'b0);
        check_val("t3_user_start", 32'(cmd_start_o), 32'd1);
        pulse(3, 1'b0);
        check_val("t3_data_start", 32'(data_start_o), 32'd1);
        pulse(0, 1'b0);
        pulse(2, 1'b0);
        pulse(1, 1'b0);
        wait_sig("t3_eot", 2, 20);
        tick();
        check_val("t3_cmd_count", 32'(n_cmd_start - base), 32'd2);
        check_val("t3_status", 32'(status_o), 32'h00);

        // CMD23 rejected: user command never issued
        base = n_cmd_start;
        n = n_data_start;
        exp_cmd.push_back('{op: 6'd23, arg: 32'd8, rsp: 3'd1});
        exp_eot.push_back(1'b1);
        send_req(6'd25, 32'h2000, 3'd1, 1'b1, 1'b0, 16'd7, 2'd2);
        tick();
        pulse(0, 1'b1);
        wait_sig("t3b_eot", 2, 20);
        repeat (5) tick();
        check_val("t3b_cmd_count", 32'(n_cmd_start - base), 32'd1);
        check_val("t3b_setcnt_err", 32'(status_o[3]), 32'd1);
        check_val("t3b_no_stop", 32'(status_o[4]), 32'd0);
        check_val("t3b_no_data", 32'(n_data_start - n), 32'd0);
        clear_status();

        // Maximum block count: CMD23 argument must not wrap
        exp_cmd.push_back('{op: 6'd23, arg: 32'h0001_0000, rsp: 3'd1});
        exp_cmd.push_back('{op: 6'd18, arg: 32'h3000,      rsp: 3'd1});
        exp_eot.push_back(1'b0);
        send_req(6'd18, 32'h3000, 3'd1, 1'b1, 1'b1, 16'hFFFF, 2'd2);
        check_val("t4_blk", 32'(data_blk_num_o), 32'hFFFF);
        tick();
        pulse(0, 1'b0);
        tick();
        pulse(0, 1'b0);
        pulse(1, 1'b0);
        wait_sig("t4_eot", 2, 20);
        tick();

        // Watchdog expiry 101 cycles after the entry reload
        timeout_i = 24'd100;
        base = n_abort;
        exp_cmd.push_back('{op: 6'd5, arg: 32'h55, rsp: 3'd1});
        exp_eot.push_back(1'b1);
        send_req(6'd5, 32'h55, 3'd1, 1'b0, 1'b0, 16'd0, 2'd0);
        n = 0;
        while (!abort_o && n < 300) begin
            tick();
            n++;
        end
        check_val("t5_abort_cycle", 32'(n), 32'd101);
        check_val("t5_eot_with_abort", 32'(eot_o), 32'd1);
        tick();
        check_val("t5_timeout_stat", 32'(status_o[2]), 32'd1);
        check_val("t5_abort_count", 32'(n_abort - base), 32'd1);
        clear_status();

        // Watchdog disabled
        timeout_i = 24'd0;
        base = n_abort;
        exp_cmd.push_back('{op: 6'd6, arg: 32'h66, rsp: 3'd1});
        exp_eot.push_back(1'b0);
        send_req(6'd6, 32'h66, 3'd1, 1'b0, 1'b0, 16'd0, 2'd0);
        repeat (10000) tick();
        check_val("t5b_no_abort", 32'(n_abort - base), 32'd0);
        check_val("t5b_still_busy", 32'(busy_o), 32'd1);
        pulse(0, 1'b0);
        wait_sig("t5b_eot", 2, 20);
        tick();
        timeout_i = 24'd1000;

        // Request while busy is dropped and flagged
        base = n_cmd_start;
        exp_cmd.push_back('{op: 6'd8, arg: 32'h1, rsp: 3'd1});
        exp_eot.push_back(1'b0);
        send_req(6'd8, 32'h1, 3'd1, 1'b0, 1'b0, 16'd0, 2'd0);
        send_req(6'd40, 32'hDEAD, 3'd2, 1'b0, 1'b0, 16'd0, 2'd0);
        check_val("t6_overrun", 32'(status_o[5]), 32'd1);
        tick();
        pulse(0, 1'b0);
        wait_sig("t6_eot", 2, 20);
        repeat (3) tick();
        check_val("t6_cmd_count", 32'(n_cmd_start - base), 32'd1);

        // Clear coincident with a new error: old bits drop, new one survives
        exp_cmd.push_back('{op: 6'd9, arg: 32'h9, rsp: 3'd1});
        exp_eot.push_back(1'b1);
        send_req(6'd9, 32'h9, 3'd1, 1'b0, 1'b0, 16'd0, 2'd0);
        tick();
        clr_stat_i = 1'b1;
        pulse(0, 1'b1);
        clr_stat_i = 1'b0;
        check_val("t7_set_wins", 32'(status_o), 32'h01);
        tick();

        // Reset in the middle of a sequence
        base = n_eot;
        exp_cmd.push_back('{op: 6'd3, arg: 32'h0, rsp: 3'd1});
        send_req(6'd3, 32'h0, 3'd1, 1'b1, 1'b1, 16'd2, 2'd1);
        tick();
        rst_i = 1'b1;
        tick();
        check_val("t8_busy", 32'(busy_o), 32'd0);
        check_val("t8_status", 32'(status_o), 32'd0);
        check_val("t8_cmd_op", 32'(cmd_op_o), 32'd0);
        rst_i = 1'b0;
        repeat (3) tick();
        check_val("t8_no_eot", 32'(n_eot - base), 32'd0);

        check_val("sb_cmd_drained", 32'(exp_cmd.size()), 32'd0);
        check_val("sb_eot_drained", 32'(exp_eot.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdio_txrx_seq.md
Name: sdio_txrx_seq

Overview:
Parametrised transaction sequencer for the SDIO uDMA channel. It sits between the register file and the SDIO command and data engines, and drives them through start/eot handshakes. It generalises single-request command plus data sequencing with selectable auto-CMD12 (stop after last block) or auto-CMD23 (set block count before transfer), a wide block counter, a programmable watchdog timeout, and sticky error status.

Parameters:
BLKNUM_W, 16, width of block-count request field (value = blocks-1)
TIMEOUT_W, 24, width of watchdog counter
STOP_OP, 12, opcode issued for auto-stop
SETCNT_OP, 23, opcode issued for auto set-block-count

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-high
clr_stat_i  in  1  clear sticky status
req_i  in  1  start request (1-cycle pulse)
req_op_i  in  6  user command opcode
req_arg_i  in  32  user command argument
req_rsp_type_i  in  3  user response type
req_data_en_i  in  1  request has a data phase
req_rwn_i  in  1  1=read, 0=write
req_blk_num_i  in  BLKNUM_W  block count minus 1
req_auto_i  in  2  0=none, 1=auto-CMD12, 2=auto-CMD23, 3=reserved (treated as 0)
timeout_i  in  TIMEOUT_W  watchdog reload; 0 disables
busy_o  out  1  sequence in progress
eot_o  out  1  1-cycle end-of-transaction pulse
err_o  out  1  qualifies eot_o; sequence ended in error
abort_o  out  1  1-cycle pulse on timeout; engines return to idle
status_o  out  8  sticky status
cmd_start_o  out  1  command engine start pulse
cmd_op_o  out  6  command opcode
cmd_arg_o  out  32  command argument
cmd_rsp_type_o  out  3  command response type
cmd_eot_i  in  1  command engine done pulse
cmd_err_i  in  1  qualifies cmd_eot_i
cmd_data_go_i  in  1  command engine allows data phase
data_start_o  out  1  data engine start pulse
data_rwn_o  out  1  latched direction
data_blk_num_o  out  BLKNUM_W  latched block count minus 1
data_last_i  in  1  last block on the bus
data_eot_i  in  1  data engine done pulse
data_err_i  in  1  qualifies data_eot_i

Behaviour:
- Reset: all outputs 0, state ST_IDLE, latched request fields 0.
- req_i accepted only in ST_IDLE. Fields are latched on acceptance. req_i while busy: ignored, status_o[5] set.
- States: ST_IDLE, ST_SETCNT, ST_MAIN, ST_STOP, ST_DONE. busy_o=1 in all but ST_IDLE.
- ST_IDLE + req_i: auto=2 & data_en goes to ST_SETCNT; otherwise ST_MAIN.
- cmd_start_o asserts exactly one cycle, on the first cycle of ST_SETCNT, ST_MAIN and ST_STOP (latency 1 from req_i to the first start).
- cmd_op/arg/rsp_type by state:
  - ST_SETCNT: SETCNT_OP, arg = zero-extended blk_num+1 (BLKNUM_W+1 bits, no wrap), rsp 1.
  - ST_MAIN: latched user fields.
  - ST_STOP: STOP_OP, arg 0, rsp 1.
- ST_SETCNT: cmd_eot_i & !cmd_err_i goes to ST_MAIN. cmd_eot_i & cmd_err_i sets status[3] and goes to ST_DONE with error.
- ST_MAIN:
  - data_start_o pulses on the first cmd_data_go_i (at most once per sequence), only if data_en.
  - Sticky flags c_done and d_done are set by cmd_eot_i and data_eot_i. l_seen is set by data_last_i.
  - Auto-stop condition: data_en & auto=1 & blk_num!=0.
  - With auto-stop: when l_seen & c_done, go to ST_STOP. l_seen before c_done is held pending, and the stop is never issued before the main response.
  - Without auto-stop: when c_done & (d_done | !data_en), go to ST_DONE.
- ST_STOP: issue the stop command. When its cmd_eot_i is seen and d_done (may precede), go to ST_DONE. status[4] set.
- Error pulses: cmd_err_i with eot sets status[0]; data_err_i with eot sets status[1]. Either makes the final err_o=1 but does not shorten the sequence (the stop is still issued).
- Watchdog:
  - Reloads with timeout_i on every state entry and on any cmd_eot_i, data_last_i or data_eot_i.
  - Decrements each cycle in the busy states except ST_DONE.
  - Reaching 0 with timeout_i!=0: abort_o pulse, status[2] set, go to ST_DONE with error.
  - A handshake in the same cycle as expiry wins (reload, no timeout).
- ST_DONE: eot_o=1 and err_o=(any error this sequence) for one cycle, then ST_IDLE. A new req_i is accepted the cycle after.
- status_o bit map: [0] cmd_err, [1] data_err, [2] timeout, [3] setcnt_err, [4] stop_issued, [5] req_overrun, [7:6]=0.
  - Sticky until clr_stat_i.
  - Set and clear in the same cycle: set wins.
- rst_i mid-sequence: immediate return to reset values. No eot_o is generated.

Test Plan:
- No-data request op=8, arg=0x1AA: one cmd_start_o with op 8, arg 0x1AA; cmd_eot_i → eot_o=1, err_o=0; data_start_o never asserted.
- Read, blk_num=3, auto=1: start op 18; cmd_data_go → data_start; data_last_i before cmd_eot_i → stop (op 12, arg 0) issued only after cmd_eot_i; eot_o after both done; status=0x10.
- Write, blk_num=7, auto=2: first start op 23 arg 8, then the user op; no op 12; eot_o err_o=0. Repeat with cmd_err_i on CMD23 → eot_o err_o=1, status[3]=1, user cmd not issued.
- BLKNUM_W=16, blk_num=0xFFFF, auto=2: CMD23 arg=0x00010000 (no wrap).
- timeout_i=100, engine silent after start: abort_o at cycle 101 after the last reload; eot_o, err_o=1; status[2]=1. timeout_i=0: no abort over 10k cycles.
- req_i while busy → ignored, status[5]=1. clr_stat_i concurrent with a new error → bit remains set. rst_i mid-ST_MAIN → busy_o=0 next cycle, no eot_o.
